h14rx_timings_video_recover: RTL and testbench

Receive-side counterpart of the TX video timing generator. It consumes per-pixel TMDS symbol classifications from the channel decoders and classifies each pixel period as Control, VideoPreamble, VideoGuard or VideoActive. It recovers the x/y raster position and measures the active geometry. It flags protocol violations and reports lock once geometry is stable, and it feeds the RX pixel unpacker and the frame-format detector.

---
 rtl/h14tx_pkg.sv | 33 +++
 rtl/h14rx_geometry_meter.sv | 119 +++++++++++
 rtl/h14rx_timings_video_recover.sv | 190 +++++++++++++++++++
 tb/tb_h14rx_timings_video_recover.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/h14tx_pkg.sv
// Shared HDMI 1.4 TX/RX types: the pixel-period classification, the RX symbol classes
// and the control-token preamble codes.
package h14tx_pkg;

   typedef enum logic [2:0] {
      Control,
      VideoPreamble,
      VideoGuard,
      VideoActive,
      DataPreamble,
      DataGuard,
      DataActive
   } period_t;

   // Enumerators carry a Sym prefix so they do not collide with period_t's Control.
   typedef enum logic [1:0] {
      SymControl,
      SymGuard,
      SymData,
      SymError
   } symbol_kind_t;

   typedef enum logic [1:0] {
      StCtrl,
      StPre,
      StGuard,
      StActive
   } rx_state_t;

   localparam logic [3:0] VideoPreambleCtl = 4'b0001;
   localparam logic [3:0] DataPreambleCtl  = 4'b0101;

endpackage

// File: rtl/h14rx_geometry_meter.sv
// Latches the measured line width and frame height. Asserts lock once two consecutive
// frames have identical nonzero height and one common width on every line.
module h14rx_geometry_meter
   import h14tx_pkg::*;
#(
   parameter int BitWidth  = 11,
   parameter int BitHeight = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 line_start,
   input  logic                 line_end,
   input  logic [BitWidth-1:0]  line_width,
   input  logic                 frame_end,
   input  logic                 proto_err,
   output logic [BitWidth-1:0]  active_width,
   output logic [BitHeight-1:0] active_height,
   output logic                 locked
);

   logic [BitWidth-1:0]  active_width_q,  active_width_d;
   logic [BitHeight-1:0] active_height_q, active_height_d;
   logic                 locked_q,        locked_d;
   logic [BitHeight-1:0] line_cnt_q,      line_cnt_d;
   logic [BitWidth-1:0]  ref_width_q,     ref_width_d;
   logic                 ref_valid_q,     ref_valid_d;
   logic                 frame_ok_q,      frame_ok_d;
   logic [BitWidth-1:0]  prev_width_q,    prev_width_d;
   logic [BitHeight-1:0] prev_height_q,   prev_height_d;
   logic                 prev_ok_q,       prev_ok_d;

   logic [BitWidth-1:0]  cur_ref_width;
   logic                 cur_ref_valid;
   logic                 cur_ok;
   logic                 frame_good;

   // A line end coinciding with a frame end is folded into the frame verdict first.
   always_comb begin
      active_width_d  = active_width_q;
      active_height_d = active_height_q;
      locked_d        = locked_q;
      line_cnt_d      = line_cnt_q;
      prev_width_d    = prev_width_q;
      prev_height_d   = prev_height_q;
      prev_ok_d       = prev_ok_q;
      cur_ref_width   = ref_width_q;
      cur_ref_valid   = ref_valid_q;
      cur_ok          = frame_ok_q;
      frame_good      = 1'b0;

      if (line_start) begin
         line_cnt_d = (&line_cnt_q) ? line_cnt_q : line_cnt_q + BitHeight'(1);
      end

      if (line_end) begin
         active_width_d = line_width;
         if (!ref_valid_q) begin
            cur_ref_width = line_width;
            cur_ref_valid = 1'b1;
         end else if (line_width != ref_width_q) begin
            cur_ok   = 1'b0;
            locked_d = 1'b0;
         end
      end

      ref_width_d = cur_ref_width;
      ref_valid_d = cur_ref_valid;
      frame_ok_d  = cur_ok;

      if (frame_end) begin
         active_height_d = line_cnt_q;
         frame_good      = cur_ok && cur_ref_valid && (line_cnt_q != '0);
         locked_d        = frame_good && prev_ok_q && (line_cnt_q == prev_height_q)
                           && (cur_ref_width == prev_width_q);
         prev_ok_d       = frame_good;
         prev_height_d   = line_cnt_q;
         prev_width_d    = cur_ref_width;
         line_cnt_d      = '0;
         ref_valid_d     = 1'b0;
         frame_ok_d      = 1'b1;
      end

      if (proto_err) begin
         locked_d   = 1'b0;
         frame_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_width_q  <= '0;
         active_height_q <= '0;
         locked_q        <= 1'b0;
         line_cnt_q      <= '0;
         ref_width_q     <= '0;
         ref_valid_q     <= 1'b0;
         frame_ok_q      <= 1'b1;
         prev_width_q    <= '0;
         prev_height_q   <= '0;
         prev_ok_q       <= 1'b0;
      end else begin
         active_width_q  <= active_width_d;
         active_height_q <= active_height_d;
         locked_q        <= locked_d;
         line_cnt_q      <= line_cnt_d;
         ref_width_q     <= ref_width_d;
         ref_valid_q     <= ref_valid_d;
         frame_ok_q      <= frame_ok_d;
         prev_width_q    <= prev_width_d;
         prev_height_q   <= prev_height_d;
         prev_ok_q       <= prev_ok_d;
      end
   end

   assign active_width  = active_width_q;
   assign active_height = active_height_q;
   assign locked        = locked_q;

endmodule

// File: rtl/h14rx_timings_video_recover.sv
// RX video timing recovery: classifies each decoded pixel period, tracks the raster
// position and feeds line/frame strobes to the geometry meter.
module h14rx_timings_video_recover
   import h14tx_pkg::*;
#(
   parameter int BitWidth        = 11,
   parameter int BitHeight       = 10,
   parameter int PreambleLength  = 8,
   parameter int GuardLength     = 2,
   parameter bit VsyncActiveHigh = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  symbol_kind_t         sym_kind,
   input  logic [3:0]           ctl,
   input  logic                 hsync,
   input  logic                 vsync,
   output period_t              timings,
   output logic [BitWidth-1:0]  x,
   output logic [BitHeight-1:0] y,
   output logic [BitWidth-1:0]  active_width,
   output logic [BitHeight-1:0] active_height,
   output logic                 locked,
   output logic                 proto_err
);

   localparam int PreW = $clog2(PreambleLength + 1);
   localparam int GrdW = $clog2(GuardLength + 1);
   localparam logic [PreW-1:0] PreFull = PreW'(PreambleLength);
   localparam logic [GrdW-1:0] GrdFull = GrdW'(GuardLength);

   rx_state_t            state_q,     state_d;
   logic [PreW-1:0]      pre_cnt_q,   pre_cnt_d;
   logic [GrdW-1:0]      g_cnt_q,     g_cnt_d;
   period_t              timings_q,   timings_d;
   logic [BitWidth-1:0]  x_q,         x_d;
   logic [BitHeight-1:0] y_q,         y_d;
   logic                 y_restart_q, y_restart_d;
   logic                 vs_prev_q,   vs_prev_d;
   logic                 proto_err_q;

   logic                 err;
   logic                 line_start;
   logic                 line_end;
   logic                 frame_end;
   logic                 vs_active;
   logic [BitWidth-1:0]  line_width;
   logic                 hsync_unused;

   assign hsync_unused = hsync;
   assign vs_active    = (vsync == VsyncActiveHigh);
   assign line_width   = (&x_q) ? x_q : x_q + BitWidth'(1);

   // Vsync edges are judged on Control symbols only; the FSM runs independently alongside.
   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      g_cnt_d     = g_cnt_q;
      timings_d   = Control;
      x_d         = x_q;
      y_d         = y_q;
      y_restart_d = y_restart_q;
      vs_prev_d   = vs_prev_q;
      err         = 1'b0;
      line_start  = 1'b0;
      line_end    = 1'b0;
      frame_end   = 1'b0;

      if (sym_kind == SymControl) begin
         vs_prev_d = vs_active;
         if (vs_active && !vs_prev_q) begin
            frame_end   = 1'b1;
            y_restart_d = 1'b1;
         end
      end

      if (sym_kind == SymError) begin
         err     = 1'b1;
         state_d = StCtrl;
      end else begin
         case (state_q)
            StCtrl: begin
               if (sym_kind == SymControl) begin
                  if (ctl == VideoPreambleCtl) begin
                     state_d   = StPre;
                     pre_cnt_d = PreW'(1);
                     timings_d = VideoPreamble;
                  end
               end else begin
                  err = 1'b1;
               end
            end
            StPre: begin
               if (sym_kind == SymControl && ctl == VideoPreambleCtl) begin
                  pre_cnt_d = (pre_cnt_q == PreFull) ? PreFull : pre_cnt_q + PreW'(1);
                  timings_d = VideoPreamble;
               end else if (sym_kind == SymControl) begin
                  state_d = StCtrl;
               end else if (sym_kind == SymGuard && pre_cnt_q == PreFull) begin
                  state_d   = StGuard;
                  g_cnt_d   = GrdW'(1);
                  timings_d = VideoGuard;
               end else begin
                  err     = 1'b1;
                  state_d = StCtrl;
               end
            end
            StGuard: begin
               if (sym_kind == SymGuard && g_cnt_q < GrdFull) begin
                  g_cnt_d   = g_cnt_q + GrdW'(1);
                  timings_d = VideoGuard;
               end else if (sym_kind == SymData && g_cnt_q == GrdFull) begin
                  state_d    = StActive;
                  timings_d  = VideoActive;
                  x_d        = '0;
                  line_start = 1'b1;
                  if (y_restart_q) begin
                     y_d         = '0;
                     y_restart_d = 1'b0;
                  end else begin
                     y_d = (&y_q) ? y_q : y_q + BitHeight'(1);
                  end
               end else begin
                  err     = 1'b1;
                  state_d = StCtrl;
               end
            end
            StActive: begin
               if (sym_kind == SymData) begin
                  timings_d = VideoActive;
                  x_d       = (&x_q) ? x_q : x_q + BitWidth'(1);
               end else if (sym_kind == SymControl) begin
                  state_d  = StCtrl;
                  line_end = 1'b1;
               end else begin
                  err     = 1'b1;
                  state_d = StCtrl;
               end
            end
            default: state_d = StCtrl;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StCtrl;
         pre_cnt_q   <= '0;
         g_cnt_q     <= '0;
         timings_q   <= Control;
         x_q         <= '0;
         y_q         <= '0;
         y_restart_q <= 1'b1;
         vs_prev_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         g_cnt_q     <= g_cnt_d;
         timings_q   <= timings_d;
         x_q         <= x_d;
         y_q         <= y_d;
         y_restart_q <= y_restart_d;
         vs_prev_q   <= vs_prev_d;
         proto_err_q <= err;
      end
   end

   h14rx_geometry_meter #(
      .BitWidth  (BitWidth),
      .BitHeight (BitHeight)
   ) u_meter (
      .clk           (clk),
      .rst_n         (rst_n),
      .line_start    (line_start),
      .line_end      (line_end),
      .line_width    (line_width),
      .frame_end     (frame_end),
      .proto_err     (err),
      .active_width  (active_width),
      .active_height (active_height),
      .locked        (locked)
   );

   assign timings   = timings_q;
   assign x         = x_q;
   assign y         = y_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_h14rx_timings_video_recover.sv
// Directed bench for the RX timing recovery: a symbol-level reference model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_h14rx_timings_video_recover;
   import h14tx_pkg::*;

   localparam int BW   = 11;
   localparam int BH   = 10;
   localparam int PL   = 8;
   localparam int GL   = 2;
   localparam int MaxX = (1 << BW) - 1;
   localparam int MaxY = (1 << BH) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   symbol_kind_t   sym_kind = SymControl;
   logic [3:0]     ctl = 4'd0;
   logic           hsync = 1'b0;
   logic           vsync = 1'b0;
   period_t        timings;
   logic [BW-1:0]  x;
   logic [BH-1:0]  y;
   logic [BW-1:0]  active_width;
   logic [BH-1:0]  active_height;
   logic           locked;
   logic           proto_err;

   int checks = 0;
   int errors = 0;

   h14rx_timings_video_recover #(
      .BitWidth(BW), .BitHeight(BH), .PreambleLength(PL), .GuardLength(GL), .VsyncActiveHigh(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sym_kind(sym_kind), .ctl(ctl), .hsync(hsync), .vsync(vsync),
      .timings(timings), .x(x), .y(y), .active_width(active_width),
      .active_height(active_height), .locked(locked), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   // Reference model state: phase is described by run lengths, not by an encoded state.
   int      preRun, guardRun, xm, ym, lines, refW, prevH, prevW, mW, mH;
   bit      inActive, yRestart, vsPrev, frameOk, prevOk, mLocked, mErr;
   period_t mTimings;

   task automatic modelReset();
      preRun = 0; guardRun = 0; inActive = 0; xm = 0; ym = 0; yRestart = 1; vsPrev = 0;
      lines = 0; refW = -1; frameOk = 1; prevOk = 0; prevH = 0; prevW = 0;
      mW = 0; mH = 0; mLocked = 0; mErr = 0; mTimings = Control;
   endtask

   task automatic modelStep(input symbol_kind_t k, input logic [3:0] c, input logic vs);
      bit err, lineEnd, frameEnd, lineStart, va, good;
      int endWidth;
      err = 0; lineEnd = 0; frameEnd = 0; lineStart = 0; endWidth = 0;
      mTimings = Control;
      if (k == SymError) begin
         err = 1; preRun = 0; guardRun = 0; inActive = 0;
      end else begin
         if (k == SymControl) begin
            va = (vs == 1'b1);
            if (va && !vsPrev) begin frameEnd = 1; yRestart = 1; end
            vsPrev = va;
         end
         if (k == SymControl) begin
            if (guardRun > 0) begin err = 1; guardRun = 0; end
            else if (inActive) begin
               lineEnd = 1; endWidth = (xm + 1 > MaxX) ? MaxX : xm + 1; inActive = 0;
            end else if (c == 4'b0001) begin
               preRun = (preRun < PL) ? preRun + 1 : PL; mTimings = VideoPreamble;
            end else preRun = 0;
         end else if (k == SymGuard) begin
            if (preRun == PL) begin preRun = 0; guardRun = 1; mTimings = VideoGuard; end
            else if (guardRun > 0 && guardRun < GL) begin guardRun++; mTimings = VideoGuard; end
            else begin err = 1; preRun = 0; guardRun = 0; inActive = 0; end
         end else begin
            if (inActive) begin
               xm = (xm == MaxX) ? MaxX : xm + 1; mTimings = VideoActive;
            end else if (guardRun == GL) begin
               guardRun = 0; inActive = 1; xm = 0; lineStart = 1; mTimings = VideoActive;
               if (yRestart) begin ym = 0; yRestart = 0; end
               else ym = (ym == MaxY) ? MaxY : ym + 1;
            end else begin err = 1; preRun = 0; guardRun = 0; end
         end
      end
      if (lineStart) lines = (lines == MaxY) ? MaxY : lines + 1;
      if (lineEnd) begin
         mW = endWidth;
         if (refW < 0) refW = endWidth;
         else if (endWidth != refW) begin frameOk = 0; mLocked = 0; end
      end
      if (frameEnd) begin
         mH = lines;
         good = frameOk && (refW >= 0) && (lines > 0);
         mLocked = good && prevOk && (lines == prevH) && (refW == prevW);
         prevOk = good; prevH = lines; prevW = refW;
         lines = 0; refW = -1; frameOk = 1;
      end
      if (err) begin mLocked = 0; frameOk = 0; end
      mErr = err;
   endtask

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      cmp("timings", int'(timings), int'(mTimings));
      cmp("x", int'(x), xm);
      cmp("y", int'(y), ym);
      cmp("active_width", int'(active_width), mW);
      cmp("active_height", int'(active_height), mH);
      cmp("locked", int'(locked), int'(mLocked));
      cmp("proto_err", int'(proto_err), int'(mErr));
   endtask

   always @(negedge rst_n) modelReset();

   always @(posedge clk) begin
      if (rst_n) begin
         modelStep(sym_kind, ctl, vsync);
         #1;
         checkOutput();
      end
   end

   task automatic applyStimulus(input symbol_kind_t k, input logic [3:0] c, input logic vs);
      @(negedge clk);
      sym_kind = k; ctl = c; vsync = vs;
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic sendRepeat(input symbol_kind_t k, input logic [3:0] c, input int n);
      for (int i = 0; i < n; i++) applyStimulus(k, c, 1'b0);
   endtask

   task automatic sendLine(input int npre, input int ngrd, input int ndata);
      sendRepeat(SymControl, 4'b0001, npre);
      sendRepeat(SymGuard, 4'd0, ngrd);
      sendRepeat(SymData, 4'd0, ndata);
      sendRepeat(SymControl, 4'd0, 2);
   endtask

   task automatic sendVsync();
      for (int i = 0; i < 3; i++) applyStimulus(SymControl, 4'd0, 1'b1);
      for (int i = 0; i < 2; i++) applyStimulus(SymControl, 4'd0, 1'b0);
   endtask

   task automatic sendFrame(input int nlines, input int width, input int badLine, input int badWidth);
      for (int i = 0; i < nlines; i++) sendLine(PL, GL, (i == badLine) ? badWidth : width);
   endtask

   task automatic checkResetValues(input string tag);
      cmp({tag, "_timings"}, int'(timings), int'(Control));
      cmp({tag, "_x"}, int'(x), 0);
      cmp({tag, "_y"}, int'(y), 0);
      cmp({tag, "_width"}, int'(active_width), 0);
      cmp({tag, "_height"}, int'(active_height), 0);
      cmp({tag, "_locked"}, int'(locked), 0);
      cmp({tag, "_proto_err"}, int'(proto_err), 0);
   endtask

   initial begin
      modelReset();
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      rst_n = 1'b1;

      // Short line before the first vsync, with per-stage literal expectations.
      sendRepeat(SymControl, 4'b0001, PL);
      settle();
      cmp("lit_pre_timings", int'(timings), int'(VideoPreamble));
      applyStimulus(SymGuard, 4'd0, 1'b0);
      settle();
      cmp("lit_guard_timings", int'(timings), int'(VideoGuard));
      applyStimulus(SymGuard, 4'd0, 1'b0);
      applyStimulus(SymData, 4'd0, 1'b0);
      settle();
      cmp("lit_first_px_timings", int'(timings), int'(VideoActive));
      cmp("lit_first_px_x", int'(x), 0);
      cmp("lit_first_px_y", int'(y), 0);
      sendRepeat(SymData, 4'd0, 3);
      applyStimulus(SymControl, 4'd0, 1'b0);
      settle();
      cmp("lit_short_width", int'(active_width), 4);
      cmp("lit_short_end_timings", int'(timings), int'(Control));

      // Two full-width frames: lock comes with the vsync closing the second.
      sendVsync();
      sendFrame(3, 1280, -1, 0);
      sendVsync();
      settle();
      cmp("lit_f1_locked", int'(locked), 0);
      cmp("lit_f1_height", int'(active_height), 3);
      sendFrame(3, 1280, -1, 0);
      sendVsync();
      settle();
      cmp("lit_f2_locked", int'(locked), 1);
      cmp("lit_f2_width", int'(active_width), 1280);
      cmp("lit_f2_height", int'(active_height), 3);

      // Preamble one token short.
      sendRepeat(SymControl, 4'b0001, PL - 1);
      applyStimulus(SymGuard, 4'd0, 1'b0);
      settle();
      cmp("lit_short_pre_err", int'(proto_err), 1);
      cmp("lit_short_pre_locked", int'(locked), 0);
      cmp("lit_short_pre_timings", int'(timings), int'(Control));
      applyStimulus(SymControl, 4'd0, 1'b0);
      settle();
      cmp("lit_err_one_cycle", int'(proto_err), 0);

      // Guard band one symbol too long; the following Data is not video.
      sendRepeat(SymControl, 4'b0001, PL);
      sendRepeat(SymGuard, 4'd0, GL + 1);
      settle();
      cmp("lit_long_guard_err", int'(proto_err), 1);
      applyStimulus(SymData, 4'd0, 1'b0);
      settle();
      cmp("lit_after_guard_timings", int'(timings), int'(Control));
      sendRepeat(SymControl, 4'd0, 2);

      // Error symbol in place of pixel 501.
      sendRepeat(SymControl, 4'b0001, PL);
      sendRepeat(SymGuard, 4'd0, GL);
      sendRepeat(SymData, 4'd0, 501);
      applyStimulus(SymError, 4'd0, 1'b0);
      settle();
      cmp("lit_error_err", int'(proto_err), 1);
      cmp("lit_error_timings", int'(timings), int'(Control));
      cmp("lit_error_x", int'(x), 500);
      cmp("lit_error_locked", int'(locked), 0);
      sendRepeat(SymControl, 4'd0, 2);

      // One narrow line in frame 2 defers lock until frames 3 and 4 agree.
      sendVsync();
      sendFrame(5, 24, -1, 0);
      sendVsync();
      sendFrame(5, 24, 2, 23);
      sendVsync();
      settle();
      cmp("lit_bad_f2_locked", int'(locked), 0);
      sendFrame(5, 24, -1, 0);
      sendVsync();
      settle();
      cmp("lit_f3_locked", int'(locked), 0);
      sendFrame(5, 24, -1, 0);
      sendVsync();
      settle();
      cmp("lit_f4_locked", int'(locked), 1);
      cmp("lit_f4_width", int'(active_width), 24);
      cmp("lit_f4_height", int'(active_height), 5);

      // Asynchronous reset in the middle of active line 100.
      sendVsync();
      sendFrame(100, 8, -1, 0);
      sendRepeat(SymControl, 4'b0001, PL);
      sendRepeat(SymGuard, 4'd0, GL);
      sendRepeat(SymData, 4'd0, 3);
      settle();
      cmp("lit_line100_y", int'(y), 100);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetValues("midline_reset");
      applyStimulus(SymControl, 4'd0, 1'b0);
      applyStimulus(SymControl, 4'd0, 1'b0);
      rst_n = 1'b1;
      sendLine(PL, GL, 6);
      sendVsync();
      sendLine(PL, GL, 6);
      settle();
      cmp("lit_post_reset_y0", int'(y), 0);
      sendLine(PL, GL, 6);
      settle();
      cmp("lit_post_reset_y1", int'(y), 1);

      // Line longer than the x range: x and the measured width saturate.
      sendLine(PL, GL, MaxX + 3);
      settle();
      cmp("lit_sat_width", int'(active_width), MaxX);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
